// File: rtl/shift_reg_pkg.sv
// Shared definitions for the universal shift register: mode encodings and burst states.
package shift_reg_pkg;

    localparam logic [2:0] MODE_HOLD  = 3'd0;
    localparam logic [2:0] MODE_LOAD  = 3'd1;
    localparam logic [2:0] MODE_SHL   = 3'd2;
    localparam logic [2:0] MODE_SHR   = 3'd3;
    localparam logic [2:0] MODE_ROTL  = 3'd4;
    localparam logic [2:0] MODE_ROTR  = 3'd5;
    localparam logic [2:0] MODE_CLEAR = 3'd6;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } burst_state_t;

    // Only shifts and rotates may be repeated as a burst.
    function automatic logic is_shift_mode(input logic [2:0] m);
        return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ROTL) || (m == MODE_ROTR);
    endfunction

endpackage

// File: rtl/shift_burst_ctrl.sv
// Burst sequencer: latches mode and length on start, then issues one step per edge
// until the count runs out, finishing with a single-cycle done pulse.
module shift_burst_ctrl
    import shift_reg_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_nshift,
    input  logic [2:0]       i_mode,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_step,
    output logic [2:0]       o_eff_mode
);

    burst_state_t     r_state, w_next_state;
    logic [CNT_W-1:0] r_cnt, w_next_cnt;
    logic [2:0]       r_mode, w_next_mode;
    logic             r_done, w_next_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_mode  <= MODE_HOLD;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            r_mode  <= w_next_mode;
            r_done  <= w_next_done;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_next_mode  = r_mode;
        w_next_done  = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_next_mode = i_mode;
                    if (is_shift_mode(i_mode) && (i_nshift != '0)) begin
                        w_next_state = BURST;
                        w_next_cnt   = i_nshift;
                    end else begin
                        // Nothing to do: acknowledge immediately so callers never stall.
                        w_next_done = 1'b1;
                    end
                end
            end
            BURST: begin
                if (r_cnt <= CNT_W'(1)) begin
                    w_next_state = IDLE;
                    w_next_cnt   = '0;
                    w_next_done  = 1'b1;
                end else begin
                    w_next_cnt = r_cnt - CNT_W'(1);
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign o_busy     = (r_state == BURST);
    assign o_step     = (r_state == BURST);
    assign o_done     = r_done;
    assign o_eff_mode = r_mode;

endmodule

// File: rtl/shift_reg_univ.sv
// Universal WIDTH-bit register: hold/load/shift/rotate/clear per cycle, plus
// counted shift/rotate bursts driven by shift_burst_ctrl.
module shift_reg_univ
    import shift_reg_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter int               CNT_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] D,
    input  logic             sin,
    input  logic             start,
    input  logic [CNT_W-1:0] nshift,
    output logic [WIDTH-1:0] Q,
    output logic             sout_l,
    output logic             sout_r,
    output logic             busy,
    output logic             done
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_next_q;
    logic [2:0]       w_op;
    logic [2:0]       w_eff_mode;
    logic             w_step;
    logic             w_busy;
    logic             w_done;

    shift_burst_ctrl #(
        .CNT_W (CNT_W)
    ) u_ctrl (
        .clk        (clk),
        .rst        (rst),
        .i_start    (start),
        .i_nshift   (nshift),
        .i_mode     (mode),
        .o_busy     (w_busy),
        .o_done     (w_done),
        .o_step     (w_step),
        .o_eff_mode (w_eff_mode)
    );

    // A burst owns the datapath; in IDLE a start edge leaves Q untouched.
    always_comb begin
        w_op = MODE_HOLD;
        if (w_step) begin
            w_op = w_eff_mode;
        end else if (!w_busy && !start && en) begin
            w_op = mode;
        end
    end

    always_comb begin
        w_next_q = r_q;
        case (w_op)
            MODE_LOAD:  w_next_q = D;
            MODE_SHL:   w_next_q = {r_q[WIDTH-2:0], sin};
            MODE_SHR:   w_next_q = {sin, r_q[WIDTH-1:1]};
            MODE_ROTL:  w_next_q = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
            MODE_ROTR:  w_next_q = {r_q[0], r_q[WIDTH-1:1]};
            MODE_CLEAR: w_next_q = RST_VAL;
            default:    w_next_q = r_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= RST_VAL;
        end else begin
            r_q <= w_next_q;
        end
    end

    assign Q      = r_q;
    assign sout_l = r_q[WIDTH-1];
    assign sout_r = r_q[0];
    assign busy   = w_busy;
    assign done   = w_done;

endmodule

// File: tb/tb_shift_reg_univ.sv
// Scoreboard bench for shift_reg_univ: stimulus queues expected Q/busy/done,
// a monitor pops and compares after each clock edge (or after an async reset).
module tb_shift_reg_univ;
    import shift_reg_pkg::*;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en = 1'b0;
    logic [2:0]       mode = MODE_HOLD;
    logic [WIDTH-1:0] D = '0;
    logic             sin = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] nshift = '0;
    logic [WIDTH-1:0] Q;
    logic             sout_l, sout_r, busy, done;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic             busy;
        logic             done;
        string            name;
    } exp_t;

    exp_t sb[$];
    int   compared = 0;
    int   mismatched = 0;
    event evAsync;

    shift_reg_univ #(
        .WIDTH   (WIDTH),
        .RST_VAL (8'h00),
        .CNT_W   (CNT_W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .mode   (mode),
        .D      (D),
        .sin    (sin),
        .start  (start),
        .nshift (nshift),
        .Q      (Q),
        .sout_l (sout_l),
        .sout_r (sout_r),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    // Compare the oldest expectation against what the DUT shows now.
    task automatic checkOutput();
        exp_t e;
        e = sb.pop_front();
        compared++;
        if (Q !== e.q || busy !== e.busy || done !== e.done ||
            sout_l !== e.q[WIDTH-1] || sout_r !== e.q[0]) begin
            mismatched++;
            $display("[TB] FAIL %s: got Q=%h busy=%b done=%b sl=%b sr=%b, expected Q=%h busy=%b done=%b",
                     e.name, Q, busy, done, sout_l, sout_r, e.q, e.busy, e.done);
        end
    endtask

    always begin
        @(posedge clk or evAsync);
        #1;
        if (sb.size() > 0) checkOutput();
    end

    task automatic expect_(input logic [WIDTH-1:0] q, input logic b, input logic d, input string name);
        exp_t e;
        e.q = q; e.busy = b; e.done = d; e.name = name;
        sb.push_back(e);
    endtask

    // One clock of stimulus; the expectation is the DUT state after the next edge.
    task automatic applyStimulus(input logic [2:0] m, input logic e, input logic [WIDTH-1:0] d,
                                 input logic s, input logic st, input logic [CNT_W-1:0] n,
                                 input logic [WIDTH-1:0] q, input logic b, input logic dn,
                                 input string name);
        @(negedge clk);
        mode = m; en = e; D = d; sin = s; start = st; nshift = n;
        expect_(q, b, dn, name);
        @(posedge clk);
    endtask

    // Asynchronous reset mid-cycle, checked before the next edge, then released.
    task automatic resetPulse(input string name);
        @(negedge clk);
        #2;
        en = 1'b0; start = 1'b0; mode = MODE_HOLD;
        rst = 1'b0;
        expect_(8'h00, 1'b0, 1'b0, name);
        -> evAsync;
        #2;
        rst = 1'b1;
        expect_(8'h00, 1'b0, 1'b0, {name, "Release"});
    endtask

    initial begin
        logic [WIDTH-1:0] expQ;
        resetPulse("powerOnReset");

        applyStimulus(MODE_LOAD,  1, 8'h5A, 0, 0, 0, 8'h5A, 0, 0, "load5A");
        resetPulse("asyncReset");
        applyStimulus(MODE_LOAD,  0, 8'hFF, 0, 0, 0, 8'h00, 0, 0, "holdAfterReset");

        applyStimulus(MODE_LOAD,  1, 8'hA5, 0, 0, 0, 8'hA5, 0, 0, "loadA5");
        applyStimulus(MODE_LOAD,  0, 8'hFF, 0, 0, 0, 8'hA5, 0, 0, "enLowHolds");
        applyStimulus(MODE_SHL,   1, 8'h00, 1, 0, 0, 8'h4B, 0, 0, "shlSin1");
        applyStimulus(MODE_SHR,   1, 8'h00, 0, 0, 0, 8'h25, 0, 0, "shrSin0");
        applyStimulus(MODE_LOAD,  1, 8'h01, 0, 0, 0, 8'h01, 0, 0, "load01");
        applyStimulus(MODE_ROTR,  1, 8'h00, 0, 0, 0, 8'h80, 0, 0, "rotrWrap");
        applyStimulus(MODE_ROTL,  1, 8'h00, 0, 0, 0, 8'h01, 0, 0, "rotlWrap");
        applyStimulus(MODE_CLEAR, 1, 8'h77, 1, 0, 0, 8'h00, 0, 0, "clear");
        applyStimulus(MODE_LOAD,  1, 8'h3C, 0, 0, 0, 8'h3C, 0, 0, "load3C");
        applyStimulus(3'd7,       1, 8'hFF, 1, 0, 0, 8'h3C, 0, 0, "reservedMode");
        applyStimulus(MODE_HOLD,  1, 8'hFF, 1, 0, 0, 8'h3C, 0, 0, "holdMode");

        applyStimulus(MODE_LOAD,  1, 8'h81, 0, 0, 0, 8'h81, 0, 0, "load81");
        applyStimulus(MODE_ROTL,  1, 8'h00, 0, 1, 3, 8'h81, 1, 0, "burstStart");
        applyStimulus(MODE_LOAD,  1, 8'hFF, 1, 0, 0, 8'h03, 1, 0, "burstRot1");
        applyStimulus(MODE_CLEAR, 0, 8'h00, 0, 0, 0, 8'h06, 1, 0, "burstRot2");
        applyStimulus(MODE_SHL,   1, 8'h55, 1, 0, 0, 8'h0C, 0, 1, "burstRot3Done");
        applyStimulus(MODE_HOLD,  0, 8'h00, 0, 0, 0, 8'h0C, 0, 0, "doneOneCycle");

        applyStimulus(MODE_SHL,   1, 8'hAA, 1, 1, 0, 8'h0C, 0, 1, "startZeroCount");
        applyStimulus(MODE_HOLD,  0, 8'h00, 0, 0, 0, 8'h0C, 0, 0, "zeroCountIdle");
        applyStimulus(MODE_LOAD,  1, 8'hAA, 0, 1, 5, 8'h0C, 0, 1, "startLoadMode");
        applyStimulus(MODE_HOLD,  0, 8'h00, 0, 0, 0, 8'h0C, 0, 0, "loadModeIdle");

        applyStimulus(MODE_LOAD,  1, 8'hFF, 0, 0, 0, 8'hFF, 0, 0, "loadFF");
        applyStimulus(MODE_SHR,   1, 8'h00, 0, 1, 6, 8'hFF, 1, 0, "abortStart");
        applyStimulus(MODE_HOLD,  0, 8'h00, 0, 0, 0, 8'h7F, 1, 0, "abortShr1");
        applyStimulus(MODE_HOLD,  0, 8'h00, 0, 0, 0, 8'h3F, 1, 0, "abortShr2");
        resetPulse("midBurstReset");
        applyStimulus(MODE_HOLD,  0, 8'h00, 0, 0, 0, 8'h00, 0, 0, "noDoneAfterAbort");
        applyStimulus(MODE_LOAD,  1, 8'h96, 0, 0, 0, 8'h96, 0, 0, "load96");
        applyStimulus(MODE_ROTR,  0, 8'h00, 0, 1, 2, 8'h96, 1, 0, "restartBurst");
        applyStimulus(MODE_HOLD,  0, 8'h00, 0, 0, 0, 8'h4B, 1, 0, "restartRot1");
        applyStimulus(MODE_HOLD,  0, 8'h00, 0, 0, 0, 8'hA5, 0, 1, "restartRot2Done");

        applyStimulus(MODE_ROTL,  0, 8'h00, 0, 1, 2, 8'hA5, 1, 0, "backToBackStart");
        applyStimulus(MODE_SHL,   1, 8'h00, 1, 1, 7, 8'h4B, 1, 0, "startWhileBusy");
        applyStimulus(MODE_HOLD,  0, 8'h00, 0, 0, 0, 8'h96, 0, 1, "backToBackDone");
        applyStimulus(MODE_HOLD,  0, 8'h00, 0, 0, 0, 8'h96, 0, 0, "backToBackIdle");

        // Shift burst longer than WIDTH: sin=1 fills the register completely.
        expQ = 8'h96;
        applyStimulus(MODE_SHL, 0, 8'h00, 1, 1, 10, expQ, 1, 0, "longShlStart");
        for (int i = 1; i <= 10; i++) begin
            expQ = {expQ[WIDTH-2:0], 1'b1};
            applyStimulus(MODE_HOLD, 0, 8'h00, 1, 0, 0, expQ, (i < 10), (i == 10),
                          $sformatf("longShl%0d", i));
        end
        applyStimulus(MODE_HOLD, 0, 8'h00, 0, 0, 0, 8'hFF, 0, 0, "longShlIdle");

        repeat (2) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL scoreboardDrain: got %0d pending, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/shift_reg_univ.md
Name: shift_reg_univ

Overview:
- Parametrised universal register; successor to the single-bit D flip-flop with reset.
- WIDTH-bit register with per-cycle mode control: hold, parallel load, shift left/right, rotate left/right, synchronous clear.
- Burst mode: a start pulse performs N consecutive shifts or rotates with busy/done handshake.
- Used as the generic storage/serialiser primitive in datapath and serial I/O blocks.

Parameters:
- WIDTH, 8, register width in bits (>=2).
- RST_VAL, 0, value loaded into Q on reset and on CLEAR (WIDTH bits).
- CNT_W, 4, width of burst shift count.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-low.
- en  input  1  single-step enable; mode is applied only when en=1 and IDLE.
- mode  input  3  operation select; encoding below.
- D  input  WIDTH  parallel load data.
- sin  input  1  serial input for SHL/SHR.
- start  input  1  burst start pulse; sampled only in IDLE.
- nshift  input  CNT_W  burst length; sampled with start.
- Q  output  WIDTH  register contents.
- sout_l  output  1  Q[WIDTH-1], combinational.
- sout_r  output  1  Q[0], combinational.
- busy  output  1  high while a burst is in progress.
- done  output  1  one-cycle pulse at burst completion.

Behaviour:
- Mode encoding:
  - 0 HOLD.
  - 1 LOAD: Q<=D.
  - 2 SHL: Q<={Q[WIDTH-2:0],sin}.
  - 3 SHR: Q<={sin,Q[WIDTH-1:1]}.
  - 4 ROTL: Q<={Q[WIDTH-2:0],Q[WIDTH-1]}.
  - 5 ROTR: Q<={Q[0],Q[WIDTH-1:1]}.
  - 6 CLEAR: Q<=RST_VAL.
  - 7 reserved, behaves as HOLD.
- Reset:
  - rst=0 immediately (no clock needed) forces Q=RST_VAL, busy=0, done=0, state IDLE, counter 0.
  - Reset mid-burst aborts the burst; no done pulse.
- State IDLE, no start: if en=1, apply mode at the edge; if en=0, Q holds. Single-step latency 1 cycle.
- State IDLE, start=1 at edge k:
  - Takes priority over en; Q is not modified at edge k.
  - Latches mode and nshift.
  - If latched mode is a shift/rotate (2-5) and nshift!=0: enter BURST, busy=1 after edge k.
  - Otherwise: stay IDLE, done=1 for the cycle after edge k, Q unchanged.
- State BURST:
  - One shift/rotate of the latched mode per edge, at edges k+1..k+n (n = latched nshift).
  - sin is sampled live at each edge for SHL/SHR.
  - en, mode, D, start and nshift are ignored.
  - After edge k+n: busy=0, done=1 for exactly one cycle, state IDLE.
  - busy is high for exactly n cycles.
- done is registered and never coincides with busy=1.
- A new start is accepted in the cycle where done=1, giving back-to-back bursts.
- nshift greater than WIDTH is legal; rotates wrap modulo WIDTH, shifts fill fully with sin.
- Counter counts down from the latched nshift; no wrap beyond 0.

Decomposition:
- Package shift_reg_pkg: mode localparams MODE_HOLD..MODE_CLEAR (3-bit); state encoding IDLE/BURST.
- Sub-module shift_burst_ctrl:
  - Contents: FSM, down counter, latched mode.
  - Inputs: start, nshift, mode.
  - Outputs: busy, done, step (shift this edge), eff_mode.
- Top level holds the datapath mux and the Q register.

Test Plan (WIDTH=8, RST_VAL=0):
- Reset: Q=8'h5A, drop rst mid-cycle -> Q=8'h00, busy=0, done=0 before the next edge; release, en=0 -> Q stays 00.
- Single-step:
  - en=1 LOAD D=A5 -> Q=A5.
  - en=0 LOAD D=FF -> Q stays A5.
  - SHL sin=1 -> 4B.
  - SHR sin=0 -> 25.
  - ROTR from Q=01 -> 80.
  - CLEAR -> 00.
  - mode 7 -> unchanged.
- Burst: Q=81, mode=ROTL, nshift=3, start 1 cycle -> Q 03, 06, 0C on successive edges; busy high 3 cycles; done high 1 cycle after Q=0C; toggling en/mode/D during the burst has no effect.
- Degenerate start:
  - nshift=0 with SHL -> done next cycle, busy never 1, Q unchanged.
  - start with mode LOAD, nshift=5 -> same result.
- Reset mid-burst: Q=FF, SHR sin=0, nshift=6, assert rst after 2nd shift (Q=3F) -> Q=00, busy=0, no done; next start with nshift=2 behaves normally.
- Back-to-back: start asserted in the done cycle -> second burst begins, busy rises the next cycle; start while busy=1 is ignored (shift count unchanged).
